spi_accel_sequencer: RTL and testbench
======================================

Name: spi_accel_sequencer

Overview:
- Parametrised SPI transaction sequencer for the 3-axis accelerometer; next generation of the fixed 5-write / 2-read controller.
- After reset it issues NUM_CFG configuration writes, taken from a flattened table port, to the existing 24-bit SPI master (DIN/SEND/DONE/DOUT).
- It then reads NUM_AXES consecutive data registers per sample, triggered by INT1 or by a poll timer, and publishes them with a valid strobe.
- Adds a DONE timeout with retry and error reporting.

Parameters:
- NUM_CFG, 5, number of config write frames (1..15).
- NUM_AXES, 2, data registers read per sample (1..8).
- RD_BASE, 8'h08, address of first data register; axis i reads RD_BASE+i.
- MODE, 0, 0 = INT1-triggered, 1 = periodic poll.
- POLL_DIV, 1000, CLK cycles between poll triggers (MODE=1).
- TIMEOUT, 4095, max CLK cycles SEND->DONE before retry.
- MAX_RETRY, 3, retries per frame before error.

Ports:
- CLK  in  1  system clock.
- ARST_L  in  1  asynchronous active-low reset.
- INT1  in  1  accelerometer data-ready, asynchronous, level.
- CFG_TABLE  in  NUM_CFG*24  config frames; entry k = bits [24k+23:24k], sent k=0 first.
- DONE  in  1  SPI master frame-complete pulse (1 cycle).
- DOUT  in  24  SPI master received frame; data byte = DOUT[7:0].
- DIN  out  24  frame to SPI master.
- SEND  out  1  start-frame pulse.
- SAMPLE  out  NUM_AXES*8  latest sample; axis i at [8i+7:8i].
- SAMPLE_VALID  out  1  one-cycle pulse when SAMPLE updates.
- CFG_DONE  out  1  high once configuration is complete.
- ERR  out  1  sticky; set when a frame exhausts MAX_RETRY.

Behaviour:
- Reset (ARST_L low, asynchronous): state IDLE; DIN=0, SEND=0, SAMPLE=0, SAMPLE_VALID=0, CFG_DONE=0, ERR=0; all counters 0. Reset mid-frame abandons the frame, and configuration restarts from entry 0 after release.
- INT1 passes through a 2-FF synchroniser before use (int_s).
- States: IDLE -> CFG_LOAD -> CFG_WAIT -> (next entry) CFG_LOAD ... -> RUN_IDLE -> RD_LOAD -> RD_WAIT -> ... -> PUBLISH -> RUN_IDLE.
- IDLE: always advances to CFG_LOAD on the next cycle.
- CFG_LOAD (1 cycle):
  - DIN <= CFG_TABLE entry cfg_idx; SEND <= 1 for exactly one cycle (registered).
  - Go to CFG_WAIT.
- CFG_WAIT, on DONE:
  - If cfg_idx == NUM_CFG-1: CFG_DONE <= 1, go to RUN_IDLE.
  - Else cfg_idx+1, go to CFG_LOAD.
- RUN_IDLE:
  - MODE=0: int_s high -> RD_LOAD with ax_idx=0.
  - MODE=1: poll counter counts 0..POLL_DIV-1 from entry to RUN_IDLE; the wrap triggers RD_LOAD. The counter holds 0 outside RUN_IDLE.
- RD_LOAD (1 cycle): DIN <= {8'h0B, RD_BASE+ax_idx (8-bit, wraps mod 256), 8'h00}; SEND pulse.
- RD_WAIT, on DONE:
  - Capture DOUT[7:0] into shadow byte ax_idx.
  - If ax_idx == NUM_AXES-1: go to PUBLISH. Else ax_idx+1, go to RD_LOAD.
- PUBLISH (1 cycle): SAMPLE <= shadow (all axes atomically); SAMPLE_VALID=1; go to RUN_IDLE. SAMPLE_VALID is 0 in every other cycle.
- Latency: INT1 rising -> first SEND = 3 cycles (2 sync + 1 decision).
- DONE outside CFG_WAIT/RD_WAIT is ignored. SEND is never asserted while waiting for DONE.
- Timeout:
  - A wait counter runs in *_WAIT and clears on entry.
  - Reaching TIMEOUT with no DONE: retry count+1, return to the matching *_LOAD and resend the same frame.
  - After MAX_RETRY failed retries: ERR <= 1 and skip the frame. A skipped read byte keeps its previous shadow value. Sequencing continues.
  - The retry count clears on each successful DONE.
- DONE in the same cycle the timeout expires counts as success.
- INT1 remaining high after PUBLISH retriggers immediately (level-sensitive).

Decomposition:
- Shared package spi_accel_pkg:
  - state enum.
  - Command constants CMD_WR=8'h0A, CMD_RD=8'h0B.
  - Frame field offsets (cmd [23:16], addr [15:8], data [7:0]).
  - Default config table constant {0A2730, 0A2802, 0A2A01, 0A2C13, 0A2D02}.
- One sub-module: spi_timeout_ctr (wait counter + retry counter, outputs expire/give_up).

Test Plan:
- Default table, DONE model 20 cycles after SEND -> 5 SEND pulses with DIN 0A2730, 0A2802, 0A2A01, 0A2C13, 0A2D02 in order; CFG_DONE rises 1 cycle after the 5th DONE; ERR=0.
- MODE=0, NUM_AXES=3, INT1 pulse, DOUT bytes 0x11/0x22/0x33 -> DIN 0B0800, 0B0900, 0B0A00; SAMPLE=24'h332211; single SAMPLE_VALID pulse.
- MODE=1, POLL_DIV=50, INT1 tied 0 -> read bursts start every 50 cycles + burst length; no activity before CFG_DONE.
- TIMEOUT=100, DONE withheld for config frame 2 -> resend 0A2802 three times; ERR set after the 4th expiry; frame 3 (0A2A01) follows.
- ARST_L low during RD_WAIT of axis 1 -> all outputs 0 asynchronously; after release, full config replays from 0A2730.
- Spurious DONE while in RUN_IDLE, and DONE coincident with timeout expiry -> no state change / treated as success with no resend.

Source files
------------

// File: rtl/spi_accel_pkg.sv
// rtl/spi_accel_pkg.sv - shared states, frame layout and default config for the accelerometer sequencer
package spi_accel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG_LOAD,
    ST_CFG_WAIT,
    ST_RUN_IDLE,
    ST_RD_LOAD,
    ST_RD_WAIT,
    ST_PUBLISH
  } state_t;

  localparam logic [7:0] CMD_WR = 8'h0A;
  localparam logic [7:0] CMD_RD = 8'h0B;

  localparam int FRAME_W  = 24;
  localparam int CMD_LSB  = 16;
  localparam int ADDR_LSB = 8;
  localparam int DATA_LSB = 0;

  // Entry 0 sits in the least significant 24 bits and is sent first.
  localparam int DEFAULT_NUM_CFG = 5;
  localparam logic [DEFAULT_NUM_CFG*FRAME_W-1:0] DEFAULT_CFG_TABLE = {
    24'h0A2D02, 24'h0A2C13, 24'h0A2A01, 24'h0A2802, 24'h0A2730
  };

  function automatic logic [FRAME_W-1:0] make_frame(input logic [7:0] cmd,
                                                    input logic [7:0] addr,
                                                    input logic [7:0] data);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[CMD_LSB +: 8]  = cmd;
    f[ADDR_LSB +: 8] = addr;
    f[DATA_LSB +: 8] = data;
    return f;
  endfunction

endpackage

// File: rtl/spi_timeout_ctr.sv
// rtl/spi_timeout_ctr.sv - SEND-to-DONE wait timer with per-frame retry budget
module spi_timeout_ctr
  import spi_accel_pkg::*;
#(
  parameter int TIMEOUT   = 4095,
  parameter int MAX_RETRY = 3
) (
  input  logic CLK,
  input  logic ARST_L,
  input  logic waiting,
  input  logic done,
  output logic expire,
  output logic give_up
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  logic [WW-1:0] wait_cnt;
  logic [RW-1:0] retry_cnt;

  // A DONE landing on the expiry cycle wins, so expiry requires no DONE.
  assign expire  = waiting && !done && (wait_cnt == WW'(TIMEOUT - 1));
  assign give_up = expire && (retry_cnt == RW'(MAX_RETRY));

  // Wait timer only advances inside a wait; any other cycle parks it at zero.
  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      wait_cnt <= '0;
    end else if (waiting && !done && !expire) begin
      wait_cnt <= wait_cnt + WW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Retry budget: spent on each expiry, refilled by a good DONE or by giving up.
  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      retry_cnt <= '0;
    end else if ((waiting && done) || give_up) begin
      retry_cnt <= '0;
    end else if (expire) begin
      retry_cnt <= retry_cnt + RW'(1);
    end
  end

endmodule

// File: rtl/spi_accel_sequencer.sv
// rtl/spi_accel_sequencer.sv - config-then-sample SPI frame sequencer for the 3-axis accelerometer
module spi_accel_sequencer
  import spi_accel_pkg::*;
#(
  parameter int         NUM_CFG   = 5,
  parameter int         NUM_AXES  = 2,
  parameter logic [7:0] RD_BASE   = 8'h08,
  parameter int         MODE      = 0,
  parameter int         POLL_DIV  = 1000,
  parameter int         TIMEOUT   = 4095,
  parameter int         MAX_RETRY = 3
) (
  input  logic                      CLK,
  input  logic                      ARST_L,
  input  logic                      INT1,
  input  logic [NUM_CFG*FRAME_W-1:0] CFG_TABLE,
  input  logic                      DONE,
  input  logic [FRAME_W-1:0]        DOUT,
  output logic [FRAME_W-1:0]        DIN,
  output logic                      SEND,
  output logic [NUM_AXES*8-1:0]     SAMPLE,
  output logic                      SAMPLE_VALID,
  output logic                      CFG_DONE,
  output logic                      ERR
);

  localparam int SW = NUM_AXES * 8;
  localparam int PW = $clog2(POLL_DIV + 1);

  state_t state, state_nxt;

  logic [3:0]         cfg_idx, ax_idx;
  logic               int_meta, int_s;
  logic [PW-1:0]      poll_cnt;
  logic               poll_wrap, run_trig;
  logic [SW-1:0]      shadow, byte_mask, byte_val;
  logic [6:0]         ax_shift;
  logic               waiting, expire, give_up, frame_ok, frame_end;
  logic               cfg_last, ax_last;
  logic [FRAME_W-1:0] cfg_entry, rd_frame;
  logic [FRAME_W-1:0] din_nxt;
  logic               send_nxt, valid_nxt, cfg_done_nxt, err_nxt;
  logic               unused_dout;

  assign unused_dout = ^DOUT[FRAME_W-1:8];

  assign waiting   = (state == ST_CFG_WAIT) || (state == ST_RD_WAIT);
  assign frame_ok  = waiting && DONE;
  // A skipped frame (retries exhausted) advances the sequence like a good one.
  assign frame_end = frame_ok || give_up;
  assign cfg_last  = (cfg_idx == 4'(NUM_CFG - 1));
  assign ax_last   = (ax_idx == 4'(NUM_AXES - 1));

  assign poll_wrap = (state == ST_RUN_IDLE) && (poll_cnt == PW'(POLL_DIV - 1));
  assign run_trig  = (MODE == 1) ? poll_wrap : int_s;

  assign cfg_entry = FRAME_W'(CFG_TABLE >> (9'(cfg_idx) * 9'd24));
  assign rd_frame  = make_frame(CMD_RD, RD_BASE + 8'(ax_idx), 8'h00);

  assign ax_shift  = 7'(ax_idx) * 7'd8;
  assign byte_mask = SW'(8'hFF) << ax_shift;
  assign byte_val  = SW'(DOUT[DATA_LSB +: 8]) << ax_shift;

  spi_timeout_ctr #(
    .TIMEOUT   (TIMEOUT),
    .MAX_RETRY (MAX_RETRY)
  ) u_timeout (
    .CLK     (CLK),
    .ARST_L  (ARST_L),
    .waiting (waiting),
    .done    (DONE),
    .expire  (expire),
    .give_up (give_up)
  );

  // Two-flop synchroniser for the asynchronous data-ready level.
  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      int_meta <= 1'b0;
      int_s    <= 1'b0;
    end else begin
      int_meta <= INT1;
      int_s    <= int_meta;
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection; an expiry without give-up returns to the load state to resend.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     state_nxt = ST_CFG_LOAD;
      ST_CFG_LOAD: state_nxt = ST_CFG_WAIT;
      ST_CFG_WAIT: begin
        if (frame_end) state_nxt = cfg_last ? ST_RUN_IDLE : ST_CFG_LOAD;
        else if (expire) state_nxt = ST_CFG_LOAD;
      end
      ST_RUN_IDLE: if (run_trig) state_nxt = ST_RD_LOAD;
      ST_RD_LOAD:  state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (frame_end) state_nxt = ax_last ? ST_PUBLISH : ST_RD_LOAD;
        else if (expire) state_nxt = ST_RD_LOAD;
      end
      ST_PUBLISH:  state_nxt = ST_RUN_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, decided by the current state.
  always_comb begin
    din_nxt      = DIN;
    send_nxt     = 1'b0;
    valid_nxt    = 1'b0;
    cfg_done_nxt = CFG_DONE;
    err_nxt      = ERR | give_up;
    case (state)
      ST_CFG_LOAD: begin
        din_nxt  = cfg_entry;
        send_nxt = 1'b1;
      end
      ST_RD_LOAD: begin
        din_nxt  = rd_frame;
        send_nxt = 1'b1;
      end
      ST_CFG_WAIT: if (frame_end && cfg_last) cfg_done_nxt = 1'b1;
      ST_PUBLISH:  valid_nxt = 1'b1;
      default:     ;
    endcase
  end

  // Output registers, frame indices and the shadow sample bytes.
  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      DIN          <= '0;
      SEND         <= 1'b0;
      SAMPLE_VALID <= 1'b0;
      CFG_DONE     <= 1'b0;
      ERR          <= 1'b0;
      SAMPLE       <= '0;
      shadow       <= '0;
      cfg_idx      <= '0;
      ax_idx       <= '0;
    end else begin
      DIN          <= din_nxt;
      SEND         <= send_nxt;
      SAMPLE_VALID <= valid_nxt;
      CFG_DONE     <= cfg_done_nxt;
      ERR          <= err_nxt;
      if (state == ST_CFG_WAIT && frame_end && !cfg_last) cfg_idx <= cfg_idx + 4'd1;
      if (state == ST_RUN_IDLE) begin
        ax_idx <= '0;
      end else if (state == ST_RD_WAIT && frame_end && !ax_last) begin
        ax_idx <= ax_idx + 4'd1;
      end
      // Only a good DONE writes the shadow; a skipped axis keeps its old byte.
      if (state == ST_RD_WAIT && frame_ok) shadow <= (shadow & ~byte_mask) | byte_val;
      if (state == ST_PUBLISH) SAMPLE <= shadow;
    end
  end

  // Poll timer: runs only while idling in poll mode and wraps into a read burst.
  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      poll_cnt <= '0;
    end else if (MODE == 1 && state == ST_RUN_IDLE && !poll_wrap) begin
      poll_cnt <= poll_cnt + PW'(1);
    end else begin
      poll_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_spi_accel_sequencer.sv
// tb/tb_spi_accel_sequencer.sv - scoreboard bench for the accelerometer SPI sequencer
module tb_spi_accel_sequencer;
  import spi_accel_pkg::*;

  localparam int A_TIMEOUT = 100;
  localparam int B_POLL    = 50;
  localparam int B_AXES    = 2;
  localparam int B_DLY     = 3;

  typedef struct {
    logic [23:0] din;
    int          dly;
    logic [7:0]  data;
    logic        err;
    logic        last_cfg;
    logic        is_cfg;
  } xfer_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic        a_arst_l, a_int1, a_resp_done, a_spur_done, a_done;
  logic [23:0] a_dout, a_din, a_sample;
  logic        a_send, a_valid, a_cfg_done, a_err;

  logic        b_arst_l, b_int1, b_done;
  logic [23:0] b_dout, b_din;
  logic [15:0] b_sample;
  logic        b_send, b_valid, b_cfg_done, b_err;

  assign a_done = a_resp_done | a_spur_done;

  spi_accel_sequencer #(
    .NUM_CFG(5), .NUM_AXES(3), .RD_BASE(8'h08), .MODE(0),
    .POLL_DIV(1000), .TIMEOUT(A_TIMEOUT), .MAX_RETRY(3)
  ) dut_a (
    .CLK(CLK), .ARST_L(a_arst_l), .INT1(a_int1), .CFG_TABLE(DEFAULT_CFG_TABLE),
    .DONE(a_done), .DOUT(a_dout), .DIN(a_din), .SEND(a_send), .SAMPLE(a_sample),
    .SAMPLE_VALID(a_valid), .CFG_DONE(a_cfg_done), .ERR(a_err)
  );

  spi_accel_sequencer #(
    .NUM_CFG(1), .NUM_AXES(B_AXES), .RD_BASE(8'h08), .MODE(1),
    .POLL_DIV(B_POLL), .TIMEOUT(100), .MAX_RETRY(3)
  ) dut_b (
    .CLK(CLK), .ARST_L(b_arst_l), .INT1(b_int1), .CFG_TABLE(24'h0A2D02),
    .DONE(b_done), .DOUT(b_dout), .DIN(b_din), .SEND(b_send), .SAMPLE(b_sample),
    .SAMPLE_VALID(b_valid), .CFG_DONE(b_cfg_done), .ERR(b_err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  xfer_t       exp_q[$];
  logic [23:0] smp_q[$];
  int          a_sends  = 0;
  int          a_valids = 0;

  function automatic void push_x(input logic [23:0] din, input int dly, input logic [7:0] data,
                                 input logic err, input logic last_cfg, input logic is_cfg);
    xfer_t x;
    x.din = din; x.dly = dly; x.data = data;
    x.err = err; x.last_cfg = last_cfg; x.is_cfg = is_cfg;
    exp_q.push_back(x);
  endfunction

  // DUT A: pop the expected frame on each SEND, check it, then answer (or withhold) DONE.
  initial begin : mon_a
    xfer_t x;
    a_resp_done = 1'b0;
    a_dout      = '0;
    forever begin
      @(negedge CLK);
      if (a_send === 1'b1) begin
        a_sends++;
        chk("a_send_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          x = exp_q.pop_front();
          chk("a_din", 32'(a_din), 32'(x.din));
          chk("a_err_at_send", 32'(a_err), 32'(x.err));
          if (x.dly >= 0) begin
            for (int i = 0; i < x.dly; i++) begin
              @(negedge CLK);
              if (a_send !== 1'b0) chk("a_send_in_wait", 32'(a_send), 32'd0);
            end
            a_resp_done = 1'b1;
            a_dout      = {16'h0, x.data};
            if (x.is_cfg) chk("a_cfg_done_pre", 32'(a_cfg_done), 32'd0);
            @(negedge CLK);
            a_resp_done = 1'b0;
            if (x.is_cfg) chk("a_cfg_done_post", 32'(a_cfg_done), 32'(x.last_cfg));
          end
        end
      end
    end
  end

  // DUT A: compare each published sample against the scoreboard.
  initial begin : mon_a_smp
    logic [23:0] e;
    forever begin
      @(negedge CLK);
      if (a_valid === 1'b1) begin
        a_valids++;
        chk("a_sample_expected", 32'(smp_q.size() != 0), 32'd1);
        if (smp_q.size() != 0) begin
          e = smp_q.pop_front();
          chk("a_sample", 32'(a_sample), 32'(e));
        end
      end
    end
  end

  int b_burst_t[$];
  int b_early  = 0;
  int b_sends  = 0;
  int b_valids = 0;

  // DUT B: fixed-latency SPI responder echoing the register address as data.
  initial begin : mon_b
    b_done = 1'b0;
    b_dout = '0;
    forever begin
      @(negedge CLK);
      if (b_send === 1'b1) begin
        if (b_sends == 0) chk("b_cfg_din", 32'(b_din), 32'h000A2D02);
        b_sends++;
        if (b_din[23:16] == CMD_RD && b_cfg_done !== 1'b1) b_early++;
        if (b_din == 24'h0B0800) b_burst_t.push_back(cyc);
        for (int i = 0; i < B_DLY; i++) @(negedge CLK);
        b_done = 1'b1;
        b_dout = {16'h0, b_din[15:8]};
        @(negedge CLK);
        b_done = 1'b0;
      end
    end
  end

  // DUT B: every poll sample carries the echoed addresses 0x08/0x09.
  initial begin : mon_b_smp
    forever begin
      @(negedge CLK);
      if (b_valid === 1'b1) begin
        b_valids++;
        chk("b_sample", 32'(b_sample), 32'h00000908);
      end
    end
  end

  task automatic chk_a_zero(input string tag);
    chk({tag, "_din"}, 32'(a_din), 32'd0);
    chk({tag, "_send"}, 32'(a_send), 32'd0);
    chk({tag, "_sample"}, 32'(a_sample), 32'd0);
    chk({tag, "_valid"}, 32'(a_valid), 32'd0);
    chk({tag, "_cfg_done"}, 32'(a_cfg_done), 32'd0);
    chk({tag, "_err"}, 32'(a_err), 32'd0);
  endtask

  task automatic wait_a_cfg_done(input int lim);
    int n;
    n = 0;
    while (a_cfg_done !== 1'b1 && n < lim) begin
      @(negedge CLK);
      n++;
    end
    chk("a_cfg_done_wait", 32'(a_cfg_done), 32'd1);
  endtask

  task automatic wait_a_sends(input int target, input int lim);
    int n;
    n = 0;
    while (a_sends < target && n < lim) begin
      @(negedge CLK);
      n++;
    end
    chk("a_sends_wait", 32'(a_sends >= target), 32'd1);
  endtask

  task automatic wait_a_valids(input int target, input int lim);
    int n;
    n = 0;
    while (a_valids < target && n < lim) begin
      @(negedge CLK);
      n++;
    end
    chk("a_valids_wait", 32'(a_valids >= target), 32'd1);
  endtask

  logic [23:0] cfg_exp [5];
  int s, v;

  initial begin : main
    cfg_exp = '{24'h0A2730, 24'h0A2802, 24'h0A2A01, 24'h0A2C13, 24'h0A2D02};
    a_arst_l = 1'b0; a_int1 = 1'b0; a_spur_done = 1'b0;
    b_arst_l = 1'b0; b_int1 = 1'b0;
    repeat (3) @(negedge CLK);
    chk_a_zero("a_reset");
    chk("b_reset_cfg_done", 32'(b_cfg_done), 32'd0);
    chk("b_reset_din", 32'(b_din), 32'd0);

    // Clean configuration with the default table.
    for (int k = 0; k < 5; k++) push_x(cfg_exp[k], 20, 8'h00, 1'b0, (k == 4), 1'b1);
    a_arst_l = 1'b1;
    b_arst_l = 1'b1;
    wait_a_cfg_done(1000);
    chk("a_err_after_cfg", 32'(a_err), 32'd0);
    chk("a_cfg_q_drained", 32'(exp_q.size()), 32'd0);

    // One INT1-triggered sample over three axes.
    push_x(24'h0B0800, 20, 8'h11, 1'b0, 1'b0, 1'b0);
    push_x(24'h0B0900, 20, 8'h22, 1'b0, 1'b0, 1'b0);
    push_x(24'h0B0A00, 20, 8'h33, 1'b0, 1'b0, 1'b0);
    smp_q.push_back(24'h332211);
    a_int1 = 1'b1;
    repeat (3) @(negedge CLK);
    a_int1 = 1'b0;
    wait_a_valids(1, 500);
    repeat (40) @(negedge CLK);
    chk("a_single_valid", 32'(a_valids), 32'd1);
    chk("a_rd_q_drained", 32'(exp_q.size()), 32'd0);

    // Stray DONE while idling must change nothing.
    s = a_sends;
    a_spur_done = 1'b1;
    @(negedge CLK);
    a_spur_done = 1'b0;
    repeat (20) @(negedge CLK);
    chk("a_spur_no_send", 32'(a_sends), 32'(s));
    chk("a_spur_no_valid", 32'(a_valids), 32'd1);
    chk("a_spur_sample_kept", 32'(a_sample), 32'h00332211);
    chk("a_spur_cfg_done", 32'(a_cfg_done), 32'd1);

    // Asynchronous reset while axis 1 waits for DONE.
    s = a_sends;
    push_x(24'h0B0800, 20, 8'h44, 1'b0, 1'b0, 1'b0);
    push_x(24'h0B0900, -1, 8'h00, 1'b0, 1'b0, 1'b0);
    a_int1 = 1'b1;
    repeat (3) @(negedge CLK);
    a_int1 = 1'b0;
    wait_a_sends(s + 2, 300);
    repeat (5) @(negedge CLK);
    @(posedge CLK);
    #2 a_arst_l = 1'b0;
    #1 chk_a_zero("a_async_rst");

    // Replay: frame 1 never answered (4 sends, then skipped), frame 3 answered on the expiry cycle.
    push_x(cfg_exp[0], 20, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 4; r++) push_x(cfg_exp[1], -1, 8'h00, 1'b0, 1'b0, 1'b1);
    push_x(cfg_exp[2], 20, 8'h00, 1'b1, 1'b0, 1'b1);
    push_x(cfg_exp[3], A_TIMEOUT - 1, 8'h00, 1'b1, 1'b0, 1'b1);
    push_x(cfg_exp[4], 20, 8'h00, 1'b1, 1'b1, 1'b1);
    repeat (3) @(negedge CLK);
    a_arst_l = 1'b1;
    wait_a_cfg_done(2000);
    chk("a_err_sticky", 32'(a_err), 32'd1);
    chk("a_retry_q_drained", 32'(exp_q.size()), 32'd0);

    // INT1 held high: the second burst starts straight after the first publish.
    v = a_valids;
    s = a_sends;
    push_x(24'h0B0800, 20, 8'h5A, 1'b1, 1'b0, 1'b0);
    push_x(24'h0B0900, 20, 8'h6B, 1'b1, 1'b0, 1'b0);
    push_x(24'h0B0A00, 20, 8'h7C, 1'b1, 1'b0, 1'b0);
    push_x(24'h0B0800, 20, 8'h01, 1'b1, 1'b0, 1'b0);
    push_x(24'h0B0900, 20, 8'h02, 1'b1, 1'b0, 1'b0);
    push_x(24'h0B0A00, 20, 8'h03, 1'b1, 1'b0, 1'b0);
    smp_q.push_back(24'h7C6B5A);
    smp_q.push_back(24'h030201);
    a_int1 = 1'b1;
    wait_a_sends(s + 4, 400);
    a_int1 = 1'b0;
    wait_a_valids(v + 2, 400);
    repeat (100) @(negedge CLK);
    chk("a_retrigger_count", 32'(a_valids), 32'(v + 2));
    chk("a_final_q_drained", 32'(exp_q.size()), 32'd0);
    chk("a_final_smp_drained", 32'(smp_q.size()), 32'd0);

    // Poll-mode instance has been free-running throughout.
    chk("b_no_early_reads", 32'(b_early), 32'd0);
    chk("b_err", 32'(b_err), 32'd0);
    chk("b_bursts_seen", 32'(b_burst_t.size() >= 4), 32'd1);
    chk("b_valids_seen", 32'(b_valids >= 3), 32'd1);
    if (b_burst_t.size() >= 4) begin
      for (int i = 1; i < 4; i++) begin
        chk("b_poll_period", 32'(b_burst_t[i] - b_burst_t[i-1]),
            32'(B_POLL + B_AXES * (B_DLY + 2) + 1));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
